uib_arbiter: RTL and testbench

UIB_ARBITER -- requirements
Module: uib_arbiter

---
 rtl/uib_arbiter.sv | 157 +++++++++++++++
 tb/tb_uib_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uib_arbiter.sv
// uib_arbiter: round-robin arbiter that lets N_MASTERS requesters share one
// bus request channel, one transaction at a time.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   m_req/m_wen       per-master request and write enable
//   m_addr/m_wdata    per-master address and write data (XLEN per lane)
//   m_mode            per-master 3-bit size/sign code, passed through to the bus
//   m_rdata           per-master read data, non-zero only on the served lane in RESP
//   m_ready/m_err     per-master one-cycle completion pulse and timeout flag
//   b_req..b_mode     request channel toward the bus, driven from latched registers
//   b_rdata/b_ready   bus response
//   grant             index of the master owning the bus
//   fsm_state         current FSM state (0=IDLE, 1=BUSY, 2=RESP) for observation
//
// Handshake: a master raises m_req with stable inputs and holds them until it
// sees m_ready (one cycle, with m_err/m_rdata valid in the same cycle). Toward
// the bus, b_req stays high with stable b_* until the cycle in which b_ready=1
// is sampled; that cycle completes the transfer. b_ready outside BUSY is ignored.
module uib_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int XLEN      = 32,
    parameter int TIMEOUT   = 255,
    localparam int GW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MASTERS-1:0]      m_req,
    input  logic [N_MASTERS-1:0]      m_wen,
    input  logic [N_MASTERS*XLEN-1:0] m_addr,
    input  logic [N_MASTERS*3-1:0]    m_mode,
    input  logic [N_MASTERS*XLEN-1:0] m_wdata,
    output logic [N_MASTERS*XLEN-1:0] m_rdata,
    output logic [N_MASTERS-1:0]      m_ready,
    output logic [N_MASTERS-1:0]      m_err,
    output logic                      b_req,
    output logic                      b_wen,
    output logic [XLEN-1:0]           b_addr,
    output logic [XLEN-1:0]           b_wdata,
    output logic [2:0]                b_mode,
    input  logic [XLEN-1:0]           b_rdata,
    input  logic                      b_ready,
    output logic [GW-1:0]             grant,
    output logic [1:0]                fsm_state
);

    localparam int MW = N_MASTERS * XLEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [GW-1:0]   ptr;
    logic [15:0]     cnt;
    logic            lat_wen;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic [2:0]      lat_mode;

    logic [GW-1:0]   winner;
    logic            any_req;
    logic [GW:0]     idx;
    logic [16:0]     cnt_next;
    logic [N_MASTERS-1:0] gnt_onehot;

    // Round-robin search: first requester at or after ptr, wrapping modulo N.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = {1'b0, ptr} + (GW+1)'(k);
            if (idx >= (GW+1)'(N_MASTERS))
                idx = idx - (GW+1)'(N_MASTERS);
            if (!any_req && m_req[idx[GW-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[GW-1:0];
            end
        end
    end

    // Wait counter compared one step ahead so the edge that ends the
    // TIMEOUT-th BUSY cycle is the abort edge.
    assign cnt_next   = {1'b0, cnt} + 17'd1;
    assign gnt_onehot = N_MASTERS'(1) << grant;

    assign b_wen     = lat_wen;
    assign b_addr    = lat_addr;
    assign b_wdata   = lat_wdata;
    assign b_mode    = lat_mode;
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            cnt       <= '0;
            lat_wen   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_mode  <= '0;
            b_req     <= 1'b0;
            m_ready   <= '0;
            m_err     <= '0;
            m_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant     <= winner;
                        lat_wen   <= m_wen[winner];
                        lat_addr  <= m_addr[winner*XLEN +: XLEN];
                        lat_wdata <= m_wdata[winner*XLEN +: XLEN];
                        lat_mode  <= m_mode[winner*3 +: 3];
                        b_req     <= 1'b1;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // A ready on the timeout cycle still wins over the abort.
                    if (b_ready) begin
                        b_req   <= 1'b0;
                        m_ready <= gnt_onehot;
                        m_err   <= '0;
                        m_rdata <= MW'(b_rdata) << (grant * XLEN);
                        state   <= RESP;
                    end else if (cnt_next == 17'(TIMEOUT)) begin
                        b_req   <= 1'b0;
                        m_ready <= gnt_onehot;
                        m_err   <= gnt_onehot;
                        m_rdata <= '0;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt_next[15:0];
                    end
                end
                RESP: begin
                    m_ready <= '0;
                    m_err   <= '0;
                    m_rdata <= '0;
                    cnt     <= '0;
                    ptr     <= (grant == GW'(N_MASTERS-1)) ? '0 : grant + 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uib_arbiter.sv
// Directed bench for uib_arbiter with two masters and a 4-cycle timeout.
module tb_uib_arbiter;

  localparam int N  = 2;
  localparam int XL = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_wen;
  logic [N*XL-1:0] m_addr;
  logic [N*3-1:0]  m_mode;
  logic [N*XL-1:0] m_wdata;
  logic [N*XL-1:0] m_rdata;
  logic [N-1:0]    m_ready;
  logic [N-1:0]    m_err;
  logic            b_req;
  logic            b_wen;
  logic [XL-1:0]   b_addr;
  logic [XL-1:0]   b_wdata;
  logic [2:0]      b_mode;
  logic [XL-1:0]   b_rdata;
  logic            b_ready;
  logic [0:0]      grant;
  logic [1:0]      fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int busy;

  uib_arbiter #(.N_MASTERS(N), .XLEN(XL), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_mode(m_mode),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_mode(b_mode), .b_rdata(b_rdata), .b_ready(b_ready),
    .grant(grant), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] mode);
    m_wen[i]            = wen;
    m_addr[i*XL +: XL]  = addr;
    m_wdata[i*XL +: XL] = wdata;
    m_mode[i*3 +: 3]    = mode;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    m_req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Acts as the slave: raises b_ready in the dly-th cycle of b_req (never
  // when dly==0) and returns in the RESP cycle with the b_req cycle count.
  task automatic serve(input int dly, input logic [31:0] data, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (b_req) begin
        nbusy++;
        b_ready = (nbusy == dly);
        b_rdata = data;
      end else begin
        b_ready = 1'b0;
        b_rdata = '0;
        if (nbusy > 0) break;
      end
    end
    b_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; m_req = '0; m_wen = '0; m_addr = '0; m_mode = '0; m_wdata = '0;
    b_rdata = '0; b_ready = 1'b0;
    step();
    step();

    // reset state
    check("rst_b_req",   64'(b_req), 64'd0);
    check("rst_m_ready", 64'(m_ready), 64'd0);
    check("rst_m_err",   64'(m_err), 64'd0);
    check("rst_m_rdata", m_rdata, 64'd0);
    check("rst_grant",   64'(grant), 64'd0);
    check("rst_state",   64'(fsm_state), 64'd0);
    check("rst_b_addr",  64'(b_addr), 64'd0);
    check("rst_b_wdata", 64'(b_wdata), 64'd0);
    check("rst_b_mode",  64'({b_wen, b_mode}), 64'd0);
    rst = 1'b0;

    // single read by master 1, ready after 3 cycles
    set_master(1, 1'b0, 32'h0000_0100, 32'h0, 3'd2);
    m_req = 2'b10;
    serve(3, 32'hDEAD_BEEF, busy);
    check("rd_busy_cycles", 64'(busy), 64'd3);
    check("rd_m_ready", 64'(m_ready), 64'h2);
    check("rd_m_err",   64'(m_err), 64'd0);
    check("rd_m_rdata", m_rdata, 64'hDEAD_BEEF_0000_0000);
    check("rd_grant",   64'(grant), 64'd1);
    m_req = '0;

    // contention out of reset: 0,1,0,1
    do_reset();
    set_master(0, 1'b0, 32'h0000_0010, 32'h0, 3'd0);
    set_master(1, 1'b0, 32'h0000_0020, 32'h0, 3'd0);
    m_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      serve(1, 32'hA0A0_0000 + 32'(i), busy);
      check("cont_grant",   64'(grant), 64'(i % 2));
      check("cont_m_ready", 64'(m_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
      check("cont_m_rdata", m_rdata,
            (i % 2 == 0) ? 64'(32'hA0A0_0000 + 32'(i))
                         : {32'hA0A0_0000 + 32'(i), 32'h0});
      check("cont_busy", 64'(busy), 64'd1);
    end
    m_req = '0;
    step();

    // timeout: master 0, slave never ready
    m_req = 2'b01;
    serve(0, 32'h5555_5555, busy);
    check("to_busy_cycles", 64'(busy), 64'd4);
    check("to_m_ready", 64'(m_ready), 64'h1);
    check("to_m_err",   64'(m_err), 64'h1);
    check("to_m_rdata", m_rdata, 64'd0);
    m_req = '0;
    step();
    check("to_idle_state", 64'(fsm_state), 64'd0);
    check("to_idle_ready", 64'(m_ready), 64'd0);
    check("to_idle_err",   64'(m_err), 64'd0);
    check("to_idle_b_req", 64'(b_req), 64'd0);

    // ready in the same cycle the counter reaches TIMEOUT
    set_master(1, 1'b0, 32'h0000_0300, 32'h0, 3'd4);
    m_req = 2'b10;
    serve(4, 32'hCAFE_F00D, busy);
    check("bnd_busy_cycles", 64'(busy), 64'd4);
    check("bnd_m_ready", 64'(m_ready), 64'h2);
    check("bnd_m_err",   64'(m_err), 64'd0);
    check("bnd_m_rdata", m_rdata, 64'hCAFE_F00D_0000_0000);
    m_req = '0;
    step();

    // stability of latched request while master 0 changes its inputs
    set_master(0, 1'b1, 32'h0000_0200, 32'h1111_2222, 3'd5);
    m_req = 2'b01;
    step();
    check("stb_b_req",   64'(b_req), 64'd1);
    check("stb_grant",   64'(grant), 64'd0);
    check("stb_b_addr",  64'(b_addr), 64'h200);
    check("stb_b_wdata", 64'(b_wdata), 64'h1111_2222);
    check("stb_b_ctl",   64'({b_wen, b_mode}), 64'hD);
    set_master(0, 1'b0, 32'hFFFF_0000, 32'h0, 3'd0);
    step();
    check("stb_hold_addr",  64'(b_addr), 64'h200);
    check("stb_hold_wdata", 64'(b_wdata), 64'h1111_2222);
    check("stb_hold_ctl",   64'({b_wen, b_mode}), 64'hD);
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    check("stb_m_ready", 64'(m_ready), 64'h1);
    check("stb_b_req_low", 64'(b_req), 64'd0);
    m_req = '0;
    step();

    // reset mid-BUSY (ptr is 1 here)
    set_master(1, 1'b0, 32'h0000_0400, 32'h0, 3'd0);
    m_req = 2'b10;
    step();
    check("mrst_b_req_before", 64'(b_req), 64'd1);
    check("mrst_grant_before", 64'(grant), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check("mrst_b_req_async", 64'(b_req), 64'd0);
    check("mrst_state",       64'(fsm_state), 64'd0);
    check("mrst_grant",       64'(grant), 64'd0);
    m_req = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mrst_no_ready", 64'(m_ready), 64'd0);
      step();
    end
    set_master(0, 1'b0, 32'h0000_0500, 32'h0, 3'd0);
    m_req = 2'b11;
    serve(2, 32'h0000_0077, busy);
    check("mrst_first_grant", 64'(grant), 64'd0);
    check("mrst_first_ready", 64'(m_ready), 64'h1);
    check("mrst_first_rdata", m_rdata, 64'h77);
    m_req = '0;
    step();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
